// File: rtl/prog_ctr_ras_pkg.sv
// Shared types and default sizes for the program counter with return-address stack.
// Holds the FSM state encoding and the default PC width and stack depth.
package prog_ctr_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_RUN,
    PC_DONE
  } pc_state_e;

endpackage

// File: rtl/prog_ctr_ras_if.sv
// Decoder-to-fetch bundle: strobes and Target in, PC and status out.
// master = decoder/sequencer side, slave = program counter.
interface prog_ctr_ras_if #(
  parameter int PC_W = 10
);

  logic            Start;
  logic            Halt;
  logic            BranchAbs;
  logic            BranchRel;
  logic            Uncond;
  logic            ALU_flag;
  logic            Call;
  logic            Ret;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic            Running;
  logic            Done;
  logic            StackEmpty;
  logic            StackFull;
  logic            StackErr;

  modport master (
    output Start, Halt, BranchAbs, BranchRel,
    output Uncond, ALU_flag, Call, Ret, Target,
    input  ProgCtr, Running, Done,
    input  StackEmpty, StackFull, StackErr
  );

  modport slave (
    input  Start, Halt, BranchAbs, BranchRel,
    input  Uncond, ALU_flag, Call, Ret, Target,
    output ProgCtr, Running, Done,
    output StackEmpty, StackFull, StackErr
  );

endinterface

// File: rtl/prog_ctr_ras_ret_stack.sv
// Return-address LIFO: push/pop/top with full, empty and sticky err.
// Ports: clk_i, rst_ni, clr_i, push_i, pop_i, din_i, top_o, full_o, empty_o, err_o.
module ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign err_o   = err_q;
  assign top_o   = mem_q[IW'(cnt_q - 1'b1)];

  // Overflowing push is dropped and underflowing pop leaves the
  // count at zero; both only raise the sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push_i) begin
        if (full_o) begin
          err_q <= 1'b1;
        end else begin
          mem_q[IW'(cnt_q)] <= din_i;
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (pop_i) begin
        if (empty_o) err_q <= 1'b1;
        else         cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_ctr_ras.sv
// Program counter with IDLE/RUN/DONE sequencing and a return-address stack.
// Ports: Clk, Reset (async active-low), bus (slave: strobes in, PC/status out).
module prog_ctr_ras
  import prog_ctr_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int RAS_DEPTH  = RAS_DEPTH_DEF,
  parameter int START_ADDR = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  prog_ctr_ras_if.slave bus
);

  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, pc_rel, top;
  logic            push, pop, clr;
  logic            full, empty, err;
  logic            taken;

  // Same-width add: sign extension is implicit modulo 2^PC_W.
  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + bus.Target;
  assign taken  = bus.Uncond | bus.ALU_flag;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= PC_IDLE;
      pc_q    <= START;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      PC_IDLE: begin
        if (bus.Start) state_d = PC_RUN;
      end
      PC_RUN: begin
        if (bus.Halt) begin
          state_d = PC_DONE;
        end else if (bus.Ret) begin
          // Empty pop only flags the error; fetch continues.
          pop  = 1'b1;
          pc_d = empty ? pc_inc : top;
        end else if (bus.Call) begin
          push = 1'b1;
          pc_d = bus.Target;
        end else if (bus.BranchAbs && taken) begin
          pc_d = bus.Target;
        end else if (bus.BranchRel && taken) begin
          pc_d = pc_rel;
        end else begin
          pc_d = pc_inc;
        end
      end
      PC_DONE: begin
        if (bus.Start) begin
          state_d = PC_RUN;
          pc_d    = START;
          clr     = 1'b1;
        end
      end
      default: state_d = PC_IDLE;
    endcase
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .top_o   (top),
    .full_o  (full),
    .empty_o (empty),
    .err_o   (err)
  );

  assign bus.ProgCtr    = pc_q;
  assign bus.Running    = (state_q == PC_RUN);
  assign bus.Done       = (state_q == PC_DONE);
  assign bus.StackEmpty = empty;
  assign bus.StackFull  = full;
  assign bus.StackErr   = err;

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Directed and random stimulus for prog_ctr_ras against a behavioural model.
// PC_W=10, RAS_DEPTH=4, START_ADDR=0.
module tb_prog_ctr_ras;

  localparam int MODW = 1024;
  localparam int DEP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  prog_ctr_ras_if #(.PC_W(10)) bus ();

  prog_ctr_ras #(
    .PC_W       (10),
    .RAS_DEPTH  (DEP),
    .START_ADDR (0)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  int chks = 0;
  int errs = 0;

  // Model: mode 0 = stopped before start, 1 = executing, 2 = finished.
  int m_pc;
  int m_mode;
  int m_stk[$];
  bit m_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_mode = 0;
    m_stk.delete();
    m_err  = 1'b0;
  endtask

  task automatic model_step(bit st, bit h, bit r, bit c,
                            bit ba, bit br, bit u, bit f, int t);
    int off;
    if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 2) begin
      if (st) begin
        m_mode = 1;
        m_pc   = 0;
        m_stk.delete();
        m_err  = 1'b0;
      end
    end else if (h) begin
      m_mode = 2;
    end else if (r) begin
      if (m_stk.size() > 0) begin
        m_pc = m_stk.pop_back();
      end else begin
        m_err = 1'b1;
        m_pc  = (m_pc + 1) % MODW;
      end
    end else if (c) begin
      if (m_stk.size() < DEP) m_stk.push_back((m_pc + 1) % MODW);
      else                    m_err = 1'b1;
      m_pc = t;
    end else if (ba && (u || f)) begin
      m_pc = t;
    end else if (br && (u || f)) begin
      off  = (t >= MODW / 2) ? t - MODW : t;
      m_pc = (m_pc + off + MODW) % MODW;
    end else begin
      m_pc = (m_pc + 1) % MODW;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"},    32'(bus.ProgCtr),    32'(m_pc));
    chk({tag, ".run"},   32'(bus.Running),    32'(m_mode == 1));
    chk({tag, ".done"},  32'(bus.Done),       32'(m_mode == 2));
    chk({tag, ".empty"}, 32'(bus.StackEmpty), 32'(m_stk.size() == 0));
    chk({tag, ".full"},  32'(bus.StackFull),  32'(m_stk.size() == DEP));
    chk({tag, ".err"},   32'(bus.StackErr),   32'(m_err));
  endtask

  task automatic step(string tag, bit st, bit h, bit r, bit c,
                      bit ba, bit br, bit u, bit f, int t);
    bus.Start     = st;
    bus.Halt      = h;
    bus.Ret       = r;
    bus.Call      = c;
    bus.BranchAbs = ba;
    bus.BranchRel = br;
    bus.Uncond    = u;
    bus.ALU_flag  = f;
    bus.Target    = 10'(t);
    model_step(st, h, r, c, ba, br, u, f, t);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic inc(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(string tag, int t);
    step(tag, 0, 0, 0, 0, 1, 0, 1, 0, t);
  endtask

  initial begin
    bus.Start = 0; bus.Halt = 0; bus.Ret = 0; bus.Call = 0;
    bus.BranchAbs = 0; bus.BranchRel = 0;
    bus.Uncond = 0; bus.ALU_flag = 0; bus.Target = '0;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;

    // Idle: strobes must be ignored.
    step("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 1, 0, 1, 0, 55);
    step("idle2", 0, 0, 0, 1, 0, 0, 0, 0, 77);
    step("idle3", 0, 0, 0, 0, 0, 1, 1, 1, 9);
    step("idle4", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_pc", 32'(bus.ProgCtr), 32'd0);

    step("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("first_fetch", 32'(bus.ProgCtr), 32'd0);
    inc("inc1");
    inc("inc2");
    inc("inc3");
    chk("pc3", 32'(bus.ProgCtr), 32'd3);

    step("rel_back", 0, 0, 0, 0, 0, 1, 0, 1, 10'h3FE);
    chk("rel_back_pc", 32'(bus.ProgCtr), 32'd1);
    jmp("to3", 3);
    step("rel_nt", 0, 0, 0, 0, 0, 1, 0, 0, 10'h3FE);
    chk("rel_nt_pc", 32'(bus.ProgCtr), 32'd4);
    step("abs_nt", 0, 0, 0, 0, 1, 0, 0, 0, 500);
    jmp("abs100", 100);
    chk("abs100_pc", 32'(bus.ProgCtr), 32'd100);
    jmp("to1023", 1023);
    inc("wrap");
    chk("wrap_pc", 32'(bus.ProgCtr), 32'd0);
    step("rel_wrap", 0, 0, 0, 0, 0, 1, 1, 0, 10'h3FF);
    chk("rel_wrap_pc", 32'(bus.ProgCtr), 32'd1023);

    jmp("to5", 5);
    step("call200", 0, 0, 0, 1, 0, 0, 0, 0, 200);
    chk("call200_pc", 32'(bus.ProgCtr), 32'd200);
    inc("c_inc1");
    inc("c_inc2");
    step("ret6", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ret6_pc", 32'(bus.ProgCtr), 32'd6);

    step("call50", 0, 0, 0, 1, 0, 0, 0, 0, 50);
    step("call60", 0, 0, 0, 1, 0, 0, 0, 0, 60);
    step("call70", 0, 0, 0, 1, 0, 0, 0, 0, 70);
    step("call80", 0, 0, 0, 1, 0, 0, 0, 0, 80);
    chk("full4", 32'(bus.StackFull), 32'd1);
    step("call90", 0, 0, 0, 1, 0, 0, 0, 0, 90);
    chk("ovf_err", 32'(bus.StackErr), 32'd1);
    chk("ovf_pc", 32'(bus.ProgCtr), 32'd90);
    step("ret_a", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ret_a_pc", 32'(bus.ProgCtr), 32'd71);
    step("ret_b", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("ret_c", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("ret_d", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ret_d_pc", 32'(bus.ProgCtr), 32'd7);
    step("ret_e", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("unf_pc", 32'(bus.ProgCtr), 32'd8);
    chk("unf_err", 32'(bus.StackErr), 32'd1);

    step("halt", 0, 1, 1, 1, 0, 0, 0, 0, 33);
    step("done1", 0, 0, 0, 0, 1, 0, 1, 0, 44);
    step("done2", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("done3", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("done_pc", 32'(bus.ProgCtr), 32'd8);
    step("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("restart_pc", 32'(bus.ProgCtr), 32'd0);
    chk("restart_err", 32'(bus.StackErr), 32'd0);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step("rnd",
           ($urandom_range(0, 15) == 0),
           (r < 4),
           (r >= 4 && r < 24),
           (r >= 24 && r < 44),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, MODW - 1)));
    end

    if (m_mode != 1) step("rerun", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("pre_rst", 0, 0, 0, 1, 0, 0, 0, 0, 321);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
